// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the ICache/DCache main-memory arbiter: state
// encodings, default line size and the saturating-increment helper.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IC   = 2'd1,
        ARB_DC   = 2'd2,
        ARB_DONE = 2'd3
    } arbState_t;

    localparam int LINE_WORDS_DEF = 8;

    function automatic logic [31:0] satInc(input logic [31:0] value);
        satInc = (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_picker.sv
// Two-way round-robin choice between ICache and DCache; remembers who won
// last so that simultaneous requests alternate.
module arb_rr_picker (
    input  logic CPU_CLK,
    input  logic CPU_RST,
    input  logic icReq,
    input  logic dcReq,
    input  logic grantEn,
    output logic pickIc,
    output logic pickDc
);

    // 0 = ICache won last (reset value, so the first tie goes to DCache)
    logic lastGrantDc;

    // Winner selection, only meaningful while the arbiter is idle
    always_comb begin
        pickDc = 1'b0;
        pickIc = 1'b0;
        if (grantEn) begin
            pickDc = dcReq & (~icReq | ~lastGrantDc);
            pickIc = icReq & (~dcReq | lastGrantDc);
        end else begin
            pickDc = 1'b0;
            pickIc = 1'b0;
        end
    end

    // Remember the most recent winner
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            lastGrantDc <= 1'b0;
        end else if (pickDc) begin
            lastGrantDc <= 1'b1;
        end else if (pickIc) begin
            lastGrantDc <= 1'b0;
        end else begin
            lastGrantDc <= lastGrantDc;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one word-wide memory port between ICache refills and DCache
// refills/write-backs, sequencing each grant as a LINE_WORDS-word burst.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int ADDR_W     = 32
) (
    input  logic                          CPU_CLK,
    input  logic                          CPU_RST,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic                          ic_rvalid,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [31:0]                   dc_wdata,
    output logic                          dc_rvalid,
    output logic                          dc_done,
    output logic [31:0]                   rdata,
    output logic [$clog2(LINE_WORDS)-1:0] word_idx,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata,
    input  logic                          mem_ack,
    output logic                          ic_wait,
    output logic                          dc_wait,
    output logic [31:0]                   ic_grant_cnt,
    output logic [31:0]                   dc_grant_cnt,
    output logic [31:0]                   conflict_cnt
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFS_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    arbState_t state, nextState;
    logic [IDX_W-1:0]        wordIdx;
    logic [ADDR_W-OFS_W-1:0] lineBase;
    logic                    weLatched;
    logic                    servingDc;
    logic                    inXfer;
    logic                    pickIc, pickDc;
    logic [31:0]             icGrantCnt, dcGrantCnt, conflictCnt;
    logic                    unusedOfs;

    arb_rr_picker uPicker (
        .CPU_CLK (CPU_CLK),
        .CPU_RST (CPU_RST),
        .icReq   (ic_req),
        .dcReq   (dc_req),
        .grantEn (state == ARB_IDLE),
        .pickIc  (pickIc),
        .pickDc  (pickDc)
    );

    // Next-state decision
    always_comb begin
        nextState = state;
        case (state)
            ARB_IDLE: begin
                if (pickDc) begin
                    nextState = ARB_DC;
                end else if (pickIc) begin
                    nextState = ARB_IC;
                end else begin
                    nextState = ARB_IDLE;
                end
            end
            ARB_IC, ARB_DC: begin
                if (mem_ack && (wordIdx == LAST_IDX)) begin
                    nextState = ARB_DONE;
                end else begin
                    nextState = state;
                end
            end
            ARB_DONE: nextState = ARB_IDLE;
            default:  nextState = ARB_IDLE;
        endcase
    end

    // State, burst word counter and grant latches
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state     <= ARB_IDLE;
            wordIdx   <= '0;
            lineBase  <= '0;
            weLatched <= 1'b0;
            servingDc <= 1'b0;
        end else begin
            state <= nextState;
            if (inXfer && mem_ack) begin
                wordIdx <= wordIdx + 1'b1;
            end else begin
                wordIdx <= wordIdx;
            end
            // Line base and direction are frozen from grant until the next grant
            if (pickDc) begin
                lineBase  <= dc_addr[ADDR_W-1:OFS_W];
                weLatched <= dc_we;
                servingDc <= 1'b1;
            end else if (pickIc) begin
                lineBase  <= ic_addr[ADDR_W-1:OFS_W];
                weLatched <= 1'b0;
                servingDc <= 1'b0;
            end else begin
                lineBase  <= lineBase;
                weLatched <= weLatched;
                servingDc <= servingDc;
            end
        end
    end

    // Saturating statistics
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            icGrantCnt  <= 32'd0;
            dcGrantCnt  <= 32'd0;
            conflictCnt <= 32'd0;
        end else begin
            if ((state == ARB_DONE) && !servingDc) begin
                icGrantCnt <= satInc(icGrantCnt);
            end else begin
                icGrantCnt <= icGrantCnt;
            end
            if ((state == ARB_DONE) && servingDc) begin
                dcGrantCnt <= satInc(dcGrantCnt);
            end else begin
                dcGrantCnt <= dcGrantCnt;
            end
            if (((state == ARB_IC) && dc_wait) || ((state == ARB_DC) && ic_wait)) begin
                conflictCnt <= satInc(conflictCnt);
            end else begin
                conflictCnt <= conflictCnt;
            end
        end
    end

    assign inXfer       = (state == ARB_IC) || (state == ARB_DC);
    assign mem_req      = inXfer;
    assign mem_we       = (state == ARB_DC) && weLatched;
    assign mem_addr     = {lineBase, wordIdx, 2'b00};
    assign mem_wdata    = mem_we ? dc_wdata : 32'd0;
    assign rdata        = mem_rdata;
    assign word_idx     = wordIdx;
    assign ic_rvalid    = (state == ARB_IC) && mem_ack;
    assign dc_rvalid    = (state == ARB_DC) && mem_ack && !weLatched;
    assign ic_done      = (state == ARB_DONE) && !servingDc;
    assign dc_done      = (state == ARB_DONE) && servingDc;
    assign ic_wait      = ic_req & ~ic_done;
    assign dc_wait      = dc_req & ~dc_done;
    assign ic_grant_cnt = icGrantCnt;
    assign dc_grant_cnt = dcGrantCnt;
    assign conflict_cnt = conflictCnt;

    // Word-offset address bits carry no information for a line request
    assign unusedOfs = ^{ic_addr[OFS_W-1:0], dc_addr[OFS_W-1:0]};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a table of per-cycle vectors for
// single-requester bursts plus hand-written arbitration/reset/saturation cases.
module tb_cache_mem_arbiter;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST = 1'b1;
    logic        ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] ic_addr = 32'd0, dc_addr = 32'd0;
    logic [31:0] dc_wdata, mem_rdata, rdata, mem_addr, mem_wdata;
    logic        ic_rvalid, ic_done, dc_rvalid, dc_done, mem_req, mem_we, ic_wait, dc_wait;
    logic [2:0]  word_idx;
    logic [31:0] ic_grant_cnt, dc_grant_cnt, conflict_cnt;

    int nTests = 0;
    int nFail  = 0;

    always #5 CPU_CLK = ~CPU_CLK;

    // DCache supplies the word selected by word_idx; memory returns a tagged address
    assign dc_wdata  = 32'h0000_00A0 + 32'(word_idx);
    assign mem_rdata = 32'hD000_0000 | mem_addr;

    cache_mem_arbiter dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rvalid(dc_rvalid), .dc_done(dc_done), .rdata(rdata), .word_idx(word_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ic_wait(ic_wait), .dc_wait(dc_wait),
        .ic_grant_cnt(ic_grant_cnt), .dc_grant_cnt(dc_grant_cnt), .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        logic        icReq, dcReq, dcWe, ack;
        logic [31:0] icAddr, dcAddr;
        logic        expMemReq, expMemWe, expIcRv, expDcRv, expIcDone, expDcDone;
        logic [31:0] expAddr, expWdata;
        logic [2:0]  expIdx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One grant cycle, LINE_WORDS words (each preceded by `stall` ack-less cycles), DONE, idle
    task automatic addBurst(input logic isDc, input logic we, input logic [31:0] addr, input int stall);
        vec_t v;
        logic [31:0] base;
        base = addr & 32'hFFFF_FFE0;
        v = '{default: '0};
        v.icReq = ~isDc; v.dcReq = isDc; v.dcWe = we;
        v.icAddr = isDc ? 32'd0 : addr;
        v.dcAddr = isDc ? addr : 32'd0;
        v.ack = 1'b1;
        vecs.push_back(v);
        for (int k = 0; k < 8; k++) begin
            v.expMemReq = 1'b1;
            v.expMemWe  = isDc & we;
            v.expAddr   = base + 32'(4 * k);
            v.expWdata  = (isDc & we) ? (32'h0000_00A0 + 32'(k)) : 32'd0;
            v.expIdx    = 3'(k);
            for (int s = 0; s < stall; s++) begin
                v.ack = 1'b0; v.expIcRv = 1'b0; v.expDcRv = 1'b0;
                vecs.push_back(v);
            end
            v.ack = 1'b1; v.expIcRv = ~isDc; v.expDcRv = isDc & ~we;
            vecs.push_back(v);
        end
        v.ack = 1'b1; v.expMemReq = 1'b0; v.expMemWe = 1'b0; v.expIcRv = 1'b0; v.expDcRv = 1'b0;
        v.expWdata = 32'd0; v.expIdx = 3'd0; v.expIcDone = ~isDc; v.expDcDone = isDc;
        vecs.push_back(v);
        v = '{default: '0};
        vecs.push_back(v);
    endtask

    task automatic runUntilDone(input logic wantDc, output int rvCnt, output logic [31:0] firstAddr,
                                output logic gotDone);
        rvCnt = 0; gotDone = 1'b0; firstAddr = 32'hFFFF_FFFF;
        for (int c = 0; c < 40 && !gotDone; c++) begin
            @(negedge CPU_CLK); #1;
            if (wantDc ? dc_rvalid : ic_rvalid) begin
                if (rvCnt == 0) firstAddr = mem_addr;
                rvCnt++;
            end
            if (wantDc ? dc_done : ic_done) gotDone = 1'b1;
        end
    endtask

    task automatic doReset();
        @(negedge CPU_CLK);
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ack = 1'b0;
        CPU_RST = 1'b1;
        @(negedge CPU_CLK);
        CPU_RST = 1'b0;
    endtask

    initial begin
        int rv, icRv, dcRv, icEarly;
        logic [31:0] fa;
        logic gd, icDoneSeen, dcDoneSeen;

        addBurst(1'b0, 1'b0, 32'h0000_1234, 0);  // ICache refill, back-to-back acks
        addBurst(1'b1, 1'b1, 32'h0000_2000, 0);  // DCache write-back
        addBurst(1'b0, 1'b0, 32'h0000_3F48, 2);  // ICache refill with 2-cycle ack gaps

        doReset();
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_word_idx", 32'(word_idx), 32'd0);
        chk("rst_ic_cnt", ic_grant_cnt, 32'd0);
        chk("rst_dc_cnt", dc_grant_cnt, 32'd0);
        chk("rst_conflict", conflict_cnt, 32'd0);

        foreach (vecs[i]) begin
            @(negedge CPU_CLK);
            ic_req = vecs[i].icReq; dc_req = vecs[i].dcReq; dc_we = vecs[i].dcWe;
            ic_addr = vecs[i].icAddr; dc_addr = vecs[i].dcAddr; mem_ack = vecs[i].ack;
            #1;
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].expMemReq));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].expMemWe));
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].expWdata);
            chk($sformatf("v%0d_ic_rvalid", i), 32'(ic_rvalid), 32'(vecs[i].expIcRv));
            chk($sformatf("v%0d_dc_rvalid", i), 32'(dc_rvalid), 32'(vecs[i].expDcRv));
            chk($sformatf("v%0d_ic_done", i), 32'(ic_done), 32'(vecs[i].expIcDone));
            chk($sformatf("v%0d_dc_done", i), 32'(dc_done), 32'(vecs[i].expDcDone));
            chk($sformatf("v%0d_word_idx", i), 32'(word_idx), 32'(vecs[i].expIdx));
            chk($sformatf("v%0d_ic_wait", i), 32'(ic_wait), 32'(vecs[i].icReq & ~vecs[i].expIcDone));
            if (vecs[i].expMemReq) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].expAddr);
            end
            if (vecs[i].expIcRv) begin
                chk($sformatf("v%0d_rdata", i), rdata, 32'hD000_0000 | vecs[i].expAddr);
            end
        end
        chk("tbl_ic_cnt", ic_grant_cnt, 32'd2);
        chk("tbl_dc_cnt", dc_grant_cnt, 32'd1);
        chk("tbl_conflict", conflict_cnt, 32'd0);

        // Simultaneous requests after reset: DCache first, then ICache
        doReset();
        ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0; mem_ack = 1'b1;
        ic_addr = 32'h0000_0100; dc_addr = 32'h0000_0200;
        icRv = 0; dcRv = 0; icEarly = 0; icDoneSeen = 1'b0; dcDoneSeen = 1'b0;
        for (int c = 0; c < 60 && !(icDoneSeen && dcDoneSeen); c++) begin
            @(negedge CPU_CLK);
            if (dcDoneSeen) dc_req = 1'b0;
            if (icDoneSeen) ic_req = 1'b0;
            #1;
            if (dc_rvalid) dcRv++;
            if (ic_rvalid) begin
                icRv++;
                if (!dcDoneSeen) icEarly++;
            end
            if (dc_done) dcDoneSeen = 1'b1;
            if (ic_done) icDoneSeen = 1'b1;
        end
        @(negedge CPU_CLK);
        ic_req = 1'b0; dc_req = 1'b0;
        #1;
        chk("tie_dc_done", 32'(dcDoneSeen), 32'd1);
        chk("tie_ic_done", 32'(icDoneSeen), 32'd1);
        chk("tie_dc_rvalids", 32'(dcRv), 32'd8);
        chk("tie_ic_rvalids", 32'(icRv), 32'd8);
        chk("tie_ic_before_dc", 32'(icEarly), 32'd0);
        chk("tie_conflict", conflict_cnt, 32'd8);
        chk("tie_ic_cnt", ic_grant_cnt, 32'd1);
        chk("tie_dc_cnt", dc_grant_cnt, 32'd1);

        // Reset in the middle of a burst, then a clean re-grant
        doReset();
        ic_req = 1'b1; ic_addr = 32'h0000_5000; mem_ack = 1'b1;
        repeat (4) @(negedge CPU_CLK);
        #1;
        chk("mid_idx_before_rst", 32'(word_idx), 32'd3);
        chk("mid_req_before_rst", 32'(mem_req), 32'd1);
        CPU_RST = 1'b1;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_word_idx", 32'(word_idx), 32'd0);
        chk("mid_rst_ic_rvalid", 32'(ic_rvalid), 32'd0);
        @(negedge CPU_CLK);
        CPU_RST = 1'b0;
        runUntilDone(1'b0, rv, fa, gd);
        ic_req = 1'b0;
        chk("regrant_done", 32'(gd), 32'd1);
        chk("regrant_rvalids", 32'(rv), 32'd8);
        chk("regrant_first_addr", fa, 32'h0000_5000);
        @(negedge CPU_CLK); #1;
        chk("regrant_ic_cnt", ic_grant_cnt, 32'd1);

        // Counter saturation from 0xFFFF_FFFE over three DCache bursts
        @(negedge CPU_CLK);
        force dut.dcGrantCnt = 32'hFFFF_FFFE;
        #1;
        release dut.dcGrantCnt;
        #1;
        chk("sat_preset", dc_grant_cnt, 32'hFFFF_FFFE);
        dc_we = 1'b0; dc_addr = 32'h0000_6000; mem_ack = 1'b1;
        for (int b = 0; b < 3; b++) begin
            dc_req = 1'b1;
            runUntilDone(1'b1, rv, fa, gd);
            dc_req = 1'b0;
            chk($sformatf("sat_b%0d_done", b), 32'(gd), 32'd1);
            @(negedge CPU_CLK); #1;
            chk($sformatf("sat_b%0d_cnt", b), dc_grant_cnt, 32'hFFFF_FFFF);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
